// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV32I opcode/funct7 constants and the funct3 map.
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base (funct7 = 0) mapping shared by R-type and I-type
    function automatic alu_op_t f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_op = ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b011:  f3_op = ALU_SLTU;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// Fetch/regfile/execute signal bundle around the ID/EX register.
interface id_ex_stage_if #(parameter int XLEN = 32);
    import alu_pkg::*;

    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            ex_valid;
    logic            ex_ready;
    alu_op_t         ex_alu_op;
    logic [XLEN-1:0] ex_src1;
    logic [XLEN-1:0] ex_src2;
    logic [4:0]      ex_rd;
    logic            ex_rd_we;
    logic            ex_illegal;

    modport master (
        input  id_valid, id_instr, rs1_data, rs2_data, ex_ready,
        output id_ready, rs1_addr, rs2_addr, ex_valid, ex_alu_op,
               ex_src1, ex_src2, ex_rd, ex_rd_we, ex_illegal
    );

    modport slave (
        output id_valid, id_instr, rs1_data, rs2_data, ex_ready,
        input  id_ready, rs1_addr, rs2_addr, ex_valid, ex_alu_op,
               ex_src1, ex_src2, ex_rd, ex_rd_we, ex_illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational RV32I ALU-op decoder: R-type and I-type ALU instructions only.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_t     alu_op,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic        illegal
);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        alu_op  = ALU_ADD;
        imm     = '0;
        use_imm = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                if (f7 == F7_BASE)                     alu_op = f3_op(f3);
                else if (f7 == F7_ALT && f3 == 3'b000) alu_op = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'b101) alu_op = ALU_SRA;
                else                                   illegal = 1'b1;
            end
            OP_I: begin
                use_imm = 1'b1;
                imm     = {{20{instr[31]}}, instr[31:20]};
                alu_op  = f3_op(f3);
                // Shifts reuse imm[11:5] as funct7 and take only a 5-bit shamt
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    imm = {27'b0, instr[24:20]};
                    if (f7 == F7_ALT && f3 == 3'b101) alu_op = ALU_SRA;
                    else if (f7 != F7_BASE)           illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_op  = ALU_ADD;
            imm     = '0;
            use_imm = 1'b0;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: decodes ALU ops and holds them in the ID/EX register with valid/ready.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    id_ex_stage_if.master bus
);
    alu_op_t         dec_op;
    logic [31:0]     dec_imm;
    logic            dec_use_imm;
    logic            dec_illegal;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            accept;
    logic            consume;

    alu_decoder u_dec (
        .instr   (bus.id_instr),
        .alu_op  (dec_op),
        .imm     (dec_imm),
        .use_imm (dec_use_imm),
        .illegal (dec_illegal)
    );

    assign bus.rs1_addr = bus.id_instr[19:15];
    assign bus.rs2_addr = bus.id_instr[24:20];
    assign bus.id_ready = !bus.ex_valid || bus.ex_ready;
    assign accept       = bus.id_valid && bus.id_ready;
    assign consume      = bus.ex_valid && bus.ex_ready;

    assign src1 = dec_illegal ? '0 : bus.rs1_data;
    assign src2 = dec_illegal ? '0 : (dec_use_imm ? dec_imm : bus.rs2_data);

    // Priority rst > flush > accept > consume; no update holds every ex_* field
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_alu_op  <= ALU_ADD;
            bus.ex_src1    <= '0;
            bus.ex_src2    <= '0;
            bus.ex_rd      <= '0;
            bus.ex_rd_we   <= 1'b0;
            bus.ex_illegal <= 1'b0;
        end else if (flush) begin
            bus.ex_valid   <= 1'b0;
        end else if (accept) begin
            bus.ex_valid   <= 1'b1;
            bus.ex_alu_op  <= dec_op;
            bus.ex_src1    <= src1;
            bus.ex_src2    <= src2;
            bus.ex_rd      <= bus.id_instr[11:7];
            bus.ex_rd_we   <= !dec_illegal && (bus.id_instr[11:7] != 5'd0);
            bus.ex_illegal <= dec_illegal;
        end else if (consume) begin
            bus.ex_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   nvec = 0;
    int   nmis = 0;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] d1, input logic [31:0] d2);
        bus.id_valid = 1'b1;
        bus.id_instr = instr;
        bus.rs1_data = d1;
        bus.rs2_data = d2;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ex(input string tag, input logic v, input logic [3:0] op,
                          input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] rd,
                          input logic we, input logic ill);
        chk({tag, ".valid"},   bus.ex_valid,   v);
        chk({tag, ".op"},      bus.ex_alu_op,  op);
        chk({tag, ".src1"},    bus.ex_src1,    s1);
        chk({tag, ".src2"},    bus.ex_src2,    s2);
        chk({tag, ".rd"},      bus.ex_rd,      rd);
        chk({tag, ".rd_we"},   bus.ex_rd_we,   we);
        chk({tag, ".illegal"}, bus.ex_illegal, ill);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.id_valid = 1'b0; bus.id_instr = '0; bus.rs1_data = '0; bus.rs2_data = '0;
        bus.ex_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_ex("reset", 1'b0, 4'd0, 0, 0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1 chk("reset.id_ready", bus.id_ready, 1'b1);

        // add x3,x1,x2
        present(32'h002081B3, 32'd5, 32'd7); bus.ex_ready = 1'b1;
        #1 chk("add.rs1_addr", bus.rs1_addr, 5'd1);
        chk("add.rs2_addr", bus.rs2_addr, 5'd2);
        tick();
        chk_ex("add", 1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);

        // sub x5,x6,x7 then srai x4,x4,3 back-to-back
        present(32'h407302B3, 32'd20, 32'd8);
        tick();
        chk_ex("sub", 1'b1, 4'd1, 32'd20, 32'd8, 5'd5, 1'b1, 1'b0);
        present(32'h40325213, 32'hFFFF_FFF0, 32'd99);
        tick();
        chk_ex("srai", 1'b1, 4'd7, 32'hFFFF_FFF0, 32'd3, 5'd4, 1'b1, 1'b0);

        // addi x1,x0,-1
        present(32'hFFF00093, 32'd0, 32'd55);
        tick();
        chk_ex("addi", 1'b1, 4'd0, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);

        // addi x0,x0,0: rd=0 must not write
        present(32'h00000013, 32'd0, 32'd0);
        tick();
        chk("nop.rd_we", bus.ex_rd_we, 1'b0);

        // funct7 0100000 with XOR is illegal
        present(32'h4020C1B3, 32'd5, 32'd7);
        tick();
        chk_ex("illegal", 1'b1, 4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);

        // slli with funct7 0100000 is illegal
        present(32'h40109093, 32'd5, 32'd7);
        tick();
        chk("slli_bad.illegal", bus.ex_illegal, 1'b1);

        // Stall: load add, then hold ex_ready low with xor waiting
        present(32'h002081B3, 32'd11, 32'd22);
        tick();
        present(32'h0020C1B3, 32'd1, 32'd2); bus.ex_ready = 1'b0;
        #1 chk("stall.id_ready0", bus.id_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ex("stall", 1'b1, 4'd0, 32'd11, 32'd22, 5'd3, 1'b1, 1'b0);
            chk("stall.id_ready", bus.id_ready, 1'b0);
        end
        bus.ex_ready = 1'b1;
        tick();
        chk_ex("unstall", 1'b1, 4'd2, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0);

        // Consume without accept
        bus.id_valid = 1'b0;
        tick();
        chk("consume.valid", bus.ex_valid, 1'b0);

        // Flush during a stall together with an accepted instruction
        present(32'h002081B3, 32'd3, 32'd4);
        tick();
        bus.ex_ready = 1'b0;
        tick();
        chk("pre_flush.valid", bus.ex_valid, 1'b1);
        present(32'h407302B3, 32'd77, 32'd1); bus.ex_ready = 1'b1; flush = 1'b1;
        #1 chk("flush.id_ready", bus.id_ready, 1'b1);
        tick();
        chk("flush.valid", bus.ex_valid, 1'b0);
        flush = 1'b0; bus.id_valid = 1'b0;
        tick();
        chk("flush.dropped", bus.ex_valid, 1'b0);

        // Reset mid-stall
        present(32'h002081B3, 32'd5, 32'd7);
        tick();
        bus.ex_ready = 1'b0; bus.id_valid = 1'b0;
        tick();
        chk("pre_rst.valid", bus.ex_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk_ex("rst_stall", 1'b0, 4'd0, 0, 0, 5'd0, 1'b0, 1'b0);
        chk("rst_stall.id_ready", bus.id_ready, 1'b1);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/issue stage feeding the execute-stage ALU in the RV32I pipeline: takes fetched instructions, decodes R-type and I-type ALU operations into the 4-bit ALU op code and operand pair, and registers them into the ID/EX pipeline register. It provides the valid/ready handshake on both sides, a flush path for control hazards, and an illegal-instruction flag. It is the producer end of the ALU's op/operand interface: the ALU consumes `ex_alu_op`, `ex_src1` and `ex_src2` directly.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard the registered op and any op accepted this cycle.
- `id_valid`  in  1  fetch presents an instruction.
- `id_ready`  out  1  stage accepts an instruction this cycle.
- `id_instr`  in  32  instruction word.
- `rs1_addr`, `rs2_addr`  out  5  combinational register-file read addresses (`id_instr[19:15]`, `id_instr[24:20]`).
- `rs1_data`, `rs2_data`  in  32  register-file read data, same cycle.
- `ex_valid`  out  1  registered op is valid.
- `ex_ready`  in  1  execute consumes the op.
- `ex_alu_op`  out  4  ALU op code.
- `ex_src1`, `ex_src2`  out  32  ALU operands.
- `ex_rd`  out  5  destination register.
- `ex_rd_we`  out  1  write-enable for `ex_rd`; 0 when `ex_rd`=0 or the op is illegal.
- `ex_illegal`  out  1  instruction is not a supported ALU op.

## Operation
- ALU op encoding: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU. Codes 10–15 are reserved and never emitted.
- **R-type** (opcode 0110011):
  - funct3 000/001/010/011/100/101/110/111 map to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 0100000 is legal only with funct3 000 (SUB) and 101 (SRA); any other funct7 is illegal.
  - `src1`=`rs1_data`, `src2`=`rs2_data`.
- **I-type** (opcode 0010011): same funct3 map.
  - `src2` = sign-extended `instr[31:20]`.
  - For funct3 001/101 (shifts), `src2` = zero-extended `instr[24:20]`.
  - SLLI requires `instr[31:25]`=0000000. SRLI/SRAI require 0000000/0100000; anything else is illegal.
- **Any other opcode:** illegal.
- **Illegal op output:** `ex_valid`=1, `ex_illegal`=1, `ex_alu_op`=0, `ex_rd_we`=0, `src1`/`src2`=0.
- **Handshake:**
  - `id_ready` = `!ex_valid || ex_ready`; it is purely combinational from those two signals.
  - Accept occurs when `id_valid && id_ready`.
  - Consume occurs when `ex_valid && ex_ready`.
- **Register update priority:** `rst` > `flush` > accept > consume.
- **Flush:** `ex_valid` is 0 on the next cycle; any instruction accepted in the flush cycle is dropped.
- **Stall:** while `ex_valid && !ex_ready`, all `ex_*` outputs hold stable.

## Timing
- Reset values: `ex_valid`=0, `ex_alu_op`=0, `ex_src1`=`ex_src2`=0, `ex_rd`=0, `ex_rd_we`=0, `ex_illegal`=0.
- `id_ready`=1 in the first cycle after reset.
- Latency is one cycle: an instruction accepted at edge N is presented with `ex_valid`=1 after edge N.
- Throughput is one instruction per cycle when `ex_ready` is held at 1.
- Simultaneous consume and accept: the register is replaced with the new op and `ex_valid` stays 1 (no bubble).
- Consume without accept: `ex_valid` goes to 0.
- `rst` asserted mid-stall returns all outputs to their reset values on the next edge.
- Register-file data must be valid in the same cycle as `id_instr`; there is no internal forwarding.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_t` enum (4-bit, values above);
  - opcode constants `OP_R`=7'b0110011 and `OP_I`=7'b0010011;
  - funct7 constants `F7_BASE`=7'b0000000 and `F7_ALT`=7'b0100000.
- The ALU uses the same package.
- Sub-module `alu_decoder` is purely combinational. It takes the instruction word and returns alu op, immediate, use-immediate and illegal.
- `id_ex_stage` wraps `alu_decoder` with the operand mux and the handshake pipeline register.

## Test plan
- **ADD:** reset, then `id_instr`=0x002081B3 (add x3,x1,x2), `rs1_data`=5, `rs2_data`=7, `ex_ready`=1. Required next cycle: `ex_alu_op`=0, `ex_src1`=5, `ex_src2`=7, `ex_rd`=3, `ex_rd_we`=1.
- **SUB then SRAI, back-to-back:**
  - 0x407302B3 (sub x5,x6,x7) → `ex_alu_op`=1, `ex_rd`=5.
  - 0x40325213 (srai x4,x4,3) → `ex_alu_op`=7, `ex_src2`=3.
  - Required: two consecutive valid cycles with no bubble.
- **ADDI:** 0xFFF00093 (addi x1,x0,-1) → `ex_alu_op`=0, `ex_src2`=0xFFFFFFFF, `ex_rd`=1.
- **Illegal:** 0x4020C1B3 (funct7 0100000 with XOR) → `ex_illegal`=1, `ex_rd_we`=0, `ex_alu_op`=0.
- **Stall:** hold `ex_ready`=0 for 3 cycles with `ex_valid`=1. Required: `id_ready`=0 and `ex_*` stable. Then raise `ex_ready` with a new instruction → op is replaced in one edge.
- **Flush during stall, plus reset mid-stall:** assert `flush` during a stall together with a new accepted instruction → `ex_valid`=0 next cycle and the instruction is dropped. Separately, assert `rst` mid-stall → all outputs return to their reset values.
